// File: rtl/vid_pkg.sv
// Shared video/frame-buffer constants and the reader FSM state encoding.
// No ports. Imported by sdram_frame_reader.
package vid_pkg;

  localparam int H_ACTIVE    = 640;
  localparam int V_ACTIVE    = 480;
  localparam int FRAME_WORDS = H_ACTIVE * V_ACTIVE;
  localparam int BURST       = 128;
  localparam int FIFO_DEPTH  = 1024;
  localparam int FIFO_AW     = 10;
  localparam int FILL_LIMIT  = 768;
  localparam int PREFILL     = 512;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DATA = 2'd2
  } rd_state_e;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level signal.
// Ports:
//   clk_i   - destination clock
//   rst_n_i - asynchronous active-low reset (output resets to 0)
//   d_i     - asynchronous input
//   q_o     - synchronized output, two clk_i cycles of latency
module sync_2ff (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/sdram_frame_reader.sv
// Frame-buffer burst reader feeding the display FIFO (clk_sdram domain only).
// Issues one fixed-length burst read at a time while the FIFO is below
// FILL_LIMIT, forwards returned words to the FIFO write port with one cycle
// of latency, and raises wait_scrn once PREFILL words are buffered.
// Optional feature macro: FRAME_RESYNC_EN (vsync_in_i restarts the frame at
// BASE_ADDR after the current burst completes).
// Ports:
//   clk_sdram_i     - the only clock
//   rst_n_i         - asynchronous active-low reset
//   rd_req_o        - burst read request, held until rd_ack_i
//   rd_addr_o       - burst start word address, stable while rd_req_o=1
//   rd_ack_i        - controller accepts the request this cycle
//   rd_valid_i      - one returned word this cycle
//   rd_data_i       - returned word
//   fifo_wrusedw_i  - FIFO write-side used words
//   fifo_wrfull_i   - FIFO full flag, write side
//   wr_fifo_o       - FIFO write strobe
//   sdram_data_o    - FIFO write data
//   wait_scrn_o     - buffer primed, display may start reading
//   vsync_in_i      - display vsync, asynchronous (used only with the macro)
//   err_o           - sticky protocol/overflow error
module sdram_frame_reader
  import vid_pkg::*;
#(
  parameter int              ADDR_W      = 24,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter int              FRAME_WORDS = vid_pkg::FRAME_WORDS,
  parameter int              BURST       = vid_pkg::BURST,
  parameter int              FIFO_AW     = vid_pkg::FIFO_AW,
  parameter int              FILL_LIMIT  = vid_pkg::FILL_LIMIT,
  parameter int              PREFILL     = vid_pkg::PREFILL
) (
  input  logic               clk_sdram_i,
  input  logic               rst_n_i,
  output logic               rd_req_o,
  output logic [ADDR_W-1:0]  rd_addr_o,
  input  logic               rd_ack_i,
  input  logic               rd_valid_i,
  input  logic [15:0]        rd_data_i,
  input  logic [FIFO_AW-1:0] fifo_wrusedw_i,
  input  logic               fifo_wrfull_i,
  output logic               wr_fifo_o,
  output logic [15:0]        sdram_data_o,
  output logic               wait_scrn_o,
  input  logic               vsync_in_i,
  output logic               err_o
);

  localparam int                CNT_W     = $clog2(BURST);
  localparam logic [CNT_W-1:0]  LAST_CNT  = CNT_W'(BURST - 1);
  localparam logic [ADDR_W-1:0] BURST_W   = ADDR_W'(BURST);
  localparam logic [ADDR_W-1:0] LAST_OFF  = ADDR_W'(FRAME_WORDS - BURST);
  localparam logic [FIFO_AW-1:0] FILL_W   = FIFO_AW'(FILL_LIMIT);
  localparam logic [FIFO_AW-1:0] PREFILL_W = FIFO_AW'(PREFILL);

  rd_state_e          state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [ADDR_W-1:0]  offset_q;
  logic [ADDR_W-1:0]  rd_addr_q;
  logic               rd_req_q;
  logic               wr_fifo_q;
  logic [15:0]        sdram_data_q;
  logic               wait_scrn_q;
  logic               err_q;
  logic [FIFO_AW-1:0] usedw_q;

  logic beat_ok;
  logic last_beat;
  logic err_d;
  logic resync_take;

  // Only beats inside a granted burst reach the FIFO; anything else is dropped.
  assign beat_ok   = rd_valid_i && (state_q == DATA);
  assign last_beat = beat_ok && (cnt_q == LAST_CNT);
  assign err_d     = (rd_valid_i && (state_q != DATA))
                   || (fifo_wrfull_i && wr_fifo_q)
                   || (rd_ack_i && !rd_req_q);

`ifdef FRAME_RESYNC_EN
  logic vsync_s;
  logic vsync_s_q;
  logic resync_pend_q;
  logic resync_pend_d;

  sync_2ff u_vsync_sync (
    .clk_i   (clk_sdram_i),
    .rst_n_i (rst_n_i),
    .d_i     (vsync_in_i),
    .q_o     (vsync_s)
  );

  // An edge arriving in the same cycle it could take effect is honoured at
  // once rather than being latched and replayed on the next burst.
  assign resync_pend_d = resync_pend_q || (vsync_s && !vsync_s_q);
  assign resync_take   = resync_pend_d && ((state_q == IDLE) || last_beat);

  always_ff @(posedge clk_sdram_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      vsync_s_q     <= 1'b0;
      resync_pend_q <= 1'b0;
    end else begin
      vsync_s_q     <= vsync_s;
      resync_pend_q <= resync_pend_d && !resync_take;
    end
  end
`else
  logic unused_vsync;
  assign unused_vsync = vsync_in_i;
  assign resync_take  = 1'b0;
`endif

  always_ff @(posedge clk_sdram_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      offset_q     <= '0;
      rd_addr_q    <= BASE_ADDR;
      rd_req_q     <= 1'b0;
      wr_fifo_q    <= 1'b0;
      sdram_data_q <= '0;
      wait_scrn_q  <= 1'b0;
      err_q        <= 1'b0;
      usedw_q      <= '0;
    end else begin
      usedw_q   <= fifo_wrusedw_i;
      wr_fifo_q <= beat_ok;
      if (beat_ok) sdram_data_q <= rd_data_i;
      if (err_d) err_q <= 1'b1;

      // A resync forces one low cycle before the level rule re-qualifies.
      if (resync_take) wait_scrn_q <= 1'b0;
      else if (usedw_q >= PREFILL_W) wait_scrn_q <= 1'b1;

      case (state_q)
        IDLE: begin
          if (resync_take) begin
            offset_q <= '0;
          end else if (usedw_q < FILL_W) begin
            state_q   <= REQ;
            rd_req_q  <= 1'b1;
            rd_addr_q <= BASE_ADDR + offset_q;
          end
        end
        REQ: begin
          if (rd_ack_i) begin
            rd_req_q <= 1'b0;
            cnt_q    <= '0;
            state_q  <= DATA;
          end
        end
        DATA: begin
          if (beat_ok) begin
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == LAST_CNT) begin
              state_q <= IDLE;
              if (resync_take || (offset_q == LAST_OFF)) offset_q <= '0;
              else offset_q <= offset_q + BURST_W;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rd_req_o     = rd_req_q;
  assign rd_addr_o    = rd_addr_q;
  assign wr_fifo_o    = wr_fifo_q;
  assign sdram_data_o = sdram_data_q;
  assign wait_scrn_o  = wait_scrn_q;
  assign err_o        = err_q;

endmodule
